// File: rtl/aes_axis_mux_pkg.sv
// -----------------------------------------------------------------------------
// aes_axis_mux_pkg
// Shared AES definitions: block/key geometry constants, the request/response
// multiplexer FSM encoding, and a small index helper used by the arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_axis_mux_pkg;

    // AES geometry constants shared with the engine side
    localparam int AES_BLOCK_W  = 128;
    localparam int AES_KEY128_W = 128;
    localparam int AES_KEY256_W = 256;
    localparam int AES_NR_128   = 10;
    localparam int AES_NR_256   = 14;

    // Width of each per-channel completed-packet counter
    localparam int PKT_CNT_W    = 16;

    // Multiplexer FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mux_state_t;

    // (base + offset) mod n, used to walk channels in round-robin order
    function automatic int rr_wrap(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/aes_axis_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin priority encoder. Searches the request
// vector starting at (last_grant+1) mod NUM_CH and returns the first
// requesting channel. Output is 0 when nothing requests (caller ignores it).
// Ports:
//   req        [NUM_CH-1:0]  request bit per channel
//   last_grant [CH_W-1:0]    channel served most recently
//   grant      [CH_W-1:0]    selected channel
// -----------------------------------------------------------------------------
module rr_arbiter
    import aes_axis_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_grant,
    output logic [CH_W-1:0]   grant
);

    logic            found;
    logic [CH_W-1:0] cand;

    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        // Offsets 1..NUM_CH so the previous winner is considered last
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'(rr_wrap(int'(last_grant), k, NUM_CH));
            if (!found && req[cand]) begin
                grant = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_axis_mux.sv
// -----------------------------------------------------------------------------
// aes_axis_mux
// Shares one AES engine between NUM_CH client AXI-Stream pairs. A client is
// granted by round-robin arbitration, its request packet is passed through
// to the engine, then the engine's response packet is routed back to the
// same client before the next arbitration.
//
// Optional feature: define AES_MUX_PKT_CNT_EN to add per-channel 16-bit
// completed-response counters on port pkt_cnt.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   s_tvalid/s_tready/s_tlast      client request streams (1 bit per channel)
//   s_tdata                        client request data, channel i at [i*W +: W]
//   eng_in_*                       request stream to the AES engine
//   eng_out_*                      response stream from the AES engine
//   m_tvalid/m_tready/m_tlast      client response streams (1 bit per channel)
//   m_tdata                        client response data, channel i at [i*W +: W]
//   grant_id                       channel currently owning the engine
//   busy                           high whenever the FSM is not IDLE
//   pkt_cnt (optional)             NUM_CH x 16-bit completed-response counters
// -----------------------------------------------------------------------------
module aes_axis_mux
    import aes_axis_mux_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CH_W             = $clog2(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               resetn,

    input  logic [NUM_CH-1:0]                  s_tvalid,
    output logic [NUM_CH-1:0]                  s_tready,
    input  logic [NUM_CH-1:0]                  s_tlast,
    input  logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] s_tdata,

    output logic                               eng_in_tvalid,
    input  logic                               eng_in_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]        eng_in_tdata,
    output logic                               eng_in_tlast,

    input  logic                               eng_out_tvalid,
    output logic                               eng_out_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0]        eng_out_tdata,
    input  logic                               eng_out_tlast,

    output logic [NUM_CH-1:0]                  m_tvalid,
    input  logic [NUM_CH-1:0]                  m_tready,
    output logic [NUM_CH-1:0]                  m_tlast,
    output logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] m_tdata,

    output logic [CH_W-1:0]                    grant_id,
    output logic                               busy
`ifdef AES_MUX_PKT_CNT_EN
    ,
    output logic [NUM_CH*PKT_CNT_W-1:0]        pkt_cnt
`endif
);

    localparam int W = AXIS_TDATA_WIDTH;

    mux_state_t      state;
    logic [CH_W-1:0] last_grant;
    logic [CH_W-1:0] arb_grant;
    logic            req_done;
    logic            resp_done;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req        (s_tvalid),
        .last_grant (last_grant),
        .grant      (arb_grant)
    );

    // Combinational pass-through. Everything is gated by the registered
    // state, so asserting reset zeroes all handshakes immediately.
    always_comb begin
        s_tready       = '0;
        eng_in_tvalid  = 1'b0;
        eng_in_tdata   = '0;
        eng_in_tlast   = 1'b0;
        eng_out_tready = 1'b0;
        m_tvalid       = '0;
        m_tlast        = '0;
        m_tdata        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == CH_W'(i)) begin
                if (state == ST_REQ) begin
                    eng_in_tvalid = s_tvalid[i];
                    eng_in_tdata  = s_tdata[i*W +: W];
                    eng_in_tlast  = s_tlast[i];
                    s_tready[i]   = eng_in_tready;
                end
                if (state == ST_RESP) begin
                    m_tvalid[i]       = eng_out_tvalid;
                    m_tlast[i]        = eng_out_tlast;
                    m_tdata[i*W +: W] = eng_out_tdata;
                    eng_out_tready    = m_tready[i];
                end
            end
        end
    end

    // Handshakes are only possible in their own state (outputs are gated)
    assign req_done  = eng_in_tvalid  & eng_in_tready  & eng_in_tlast;
    assign resp_done = eng_out_tvalid & eng_out_tready & eng_out_tlast;

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            grant_id   <= '0;
            last_grant <= CH_W'(NUM_CH - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|s_tvalid) begin
                        grant_id <= arb_grant;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_done) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_done) begin
                        last_grant <= grant_id;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef AES_MUX_PKT_CNT_EN
    logic [PKT_CNT_W-1:0] cnt [NUM_CH];

    // Counts completed responses; wraps naturally at 0xFFFF
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else if (resp_done) begin
            cnt[grant_id] <= cnt[grant_id] + PKT_CNT_W'(1);
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_aes_axis_mux.sv
// -----------------------------------------------------------------------------
// tb_aes_axis_mux
// Self-checking bench for aes_axis_mux (NUM_CH=4, 32-bit data). Directed
// scenarios plus randomized traffic compared against a transaction-level
// model of the arbitration and routing rules.
// -----------------------------------------------------------------------------
module tb_aes_axis_mux;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int CHW = 2;

    logic             clk = 1'b0;
    logic             resetn;
    logic [N-1:0]     s_tvalid, s_tready, s_tlast;
    logic [N*W-1:0]   s_tdata;
    logic             eng_in_tvalid, eng_in_tready, eng_in_tlast;
    logic [W-1:0]     eng_in_tdata;
    logic             eng_out_tvalid, eng_out_tready, eng_out_tlast;
    logic [W-1:0]     eng_out_tdata;
    logic [N-1:0]     m_tvalid, m_tready, m_tlast;
    logic [N*W-1:0]   m_tdata;
    logic [CHW-1:0]   grant_id;
    logic             busy;
`ifdef AES_MUX_PKT_CNT_EN
    logic [N*16-1:0]  pkt_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_axis_mux #(
        .NUM_CH           (N),
        .AXIS_TDATA_WIDTH (W),
        .CH_W             (CHW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .s_tvalid       (s_tvalid),
        .s_tready       (s_tready),
        .s_tlast        (s_tlast),
        .s_tdata        (s_tdata),
        .eng_in_tvalid  (eng_in_tvalid),
        .eng_in_tready  (eng_in_tready),
        .eng_in_tdata   (eng_in_tdata),
        .eng_in_tlast   (eng_in_tlast),
        .eng_out_tvalid (eng_out_tvalid),
        .eng_out_tready (eng_out_tready),
        .eng_out_tdata  (eng_out_tdata),
        .eng_out_tlast  (eng_out_tlast),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .m_tdata        (m_tdata),
        .grant_id       (grant_id),
        .busy           (busy)
`ifdef AES_MUX_PKT_CNT_EN
        ,
        .pkt_cnt        (pkt_cnt)
`endif
    );

    // Round-robin rule: first requester after the previous winner
    function automatic logic [CHW-1:0] rr_pick(input logic [CHW-1:0] last, input logic [N-1:0] req);
        logic [CHW-1:0] c;
        for (int k = 1; k <= N; k++) begin
            c = CHW'((int'(last) + k) % N);
            if (req[c]) return c;
        end
        return '0;
    endfunction

    task automatic clear_inputs();
        s_tvalid = '0; s_tlast = '0; s_tdata = '0;
        eng_in_tready = 1'b0;
        eng_out_tvalid = 1'b0; eng_out_tdata = '0; eng_out_tlast = 1'b0;
        m_tready = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        s_tvalid = '1;
        eng_in_tready = 1'b1;
        eng_out_tvalid = 1'b1;
        m_tready = '1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL rst_grant: got %0d expected 0", grant_id); end
        n_checks++; if ({eng_in_tvalid, eng_out_tready, s_tready, m_tvalid} !== 10'd0) begin
            n_fail++; $display("FAIL rst_handshake: got in_v=%0b out_r=%0b s_r=%b m_v=%b expected all 0",
                               eng_in_tvalid, eng_out_tready, s_tready, m_tvalid);
        end
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || s_tready !== 4'd0) begin
            n_fail++; $display("FAIL rst_hold: got busy=%0b s_tready=%b expected 0/0000", busy, s_tready);
        end
        resetn = 1'b1;
        clear_inputs();
    endtask

    task automatic test_single_packet();
        do_reset();
        s_tvalid = 4'b0100; s_tdata[2*W +: W] = 32'hA0; eng_in_tready = 1'b1; m_tready = '1;
        #1;
        n_checks++; if (busy !== 1'b0 || eng_in_tvalid !== 1'b0 || s_tready !== 4'd0) begin
            n_fail++; $display("FAIL sp_idle_forward: got busy=%0b in_v=%0b s_r=%b expected 0/0/0000", busy, eng_in_tvalid, s_tready);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_tdata[2*W +: W] = 32'hA0 + 32'(b);
            s_tlast[2] = (b == 3);
            #1;
            n_checks++; if (eng_in_tvalid !== 1'b1 || eng_in_tdata !== 32'hA0 + 32'(b) || eng_in_tlast !== (b == 3)) begin
                n_fail++; $display("FAIL sp_beat%0d: got v=%0b d=%h l=%0b expected 1/%h/%0b", b, eng_in_tvalid, eng_in_tdata, eng_in_tlast, 32'hA0 + 32'(b), (b == 3));
            end
            n_checks++; if (grant_id !== 2'd2 || busy !== 1'b1 || s_tready !== 4'b0100) begin
                n_fail++; $display("FAIL sp_grant%0d: got g=%0d busy=%0b s_r=%b expected 2/1/0100", b, grant_id, busy, s_tready);
            end
        end
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
        eng_out_tvalid = 1'b1; eng_out_tdata = 32'hC5; eng_out_tlast = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b1 || eng_in_tvalid !== 1'b0 || m_tvalid !== 4'b0100 || m_tdata[2*W +: W] !== 32'hC5 || eng_out_tready !== 1'b1) begin
            n_fail++; $display("FAIL sp_resp: got busy=%0b in_v=%0b m_v=%b d=%h out_r=%0b expected 1/0/0100/c5/1",
                               busy, eng_in_tvalid, m_tvalid, m_tdata[2*W +: W], eng_out_tready);
        end
        @(negedge clk);
        eng_out_tdata = 32'hC6; eng_out_tlast = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b1 || m_tlast !== 4'b0100) begin
            n_fail++; $display("FAIL sp_resp_last: got busy=%0b m_tlast=%b expected 1/0100", busy, m_tlast);
        end
        @(negedge clk);
        eng_out_tvalid = 1'b0; eng_out_tlast = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || m_tvalid !== 4'd0 || eng_out_tready !== 1'b0) begin
            n_fail++; $display("FAIL sp_done: got busy=%0b m_v=%b out_r=%0b expected 0/0000/0", busy, m_tvalid, eng_out_tready);
        end
    endtask

    task automatic test_round_robin();
        logic [CHW-1:0] seq [5];
        logic [W-1:0]   dat [5];
        int got = 0;
        do_reset();
        s_tvalid = '1; s_tlast = '1;
        for (int ch = 0; ch < N; ch++) s_tdata[ch*W +: W] = 32'h100 + 32'(ch);
        eng_in_tready = 1'b1; eng_out_tvalid = 1'b1; eng_out_tlast = 1'b1; m_tready = '1;
        for (int c = 0; c < 40 && got < 5; c++) begin
            @(negedge clk);
            #1;
            if (eng_in_tvalid && eng_in_tready) begin
                seq[got] = grant_id;
                dat[got] = eng_in_tdata;
                got++;
            end
        end
        n_checks++; if (got !== 5) begin n_fail++; $display("FAIL rr_count: got %0d packets expected 5", got); end
        for (int k = 0; k < got; k++) begin
            n_checks++; if (seq[k] !== CHW'(k % N) || dat[k] !== 32'h100 + 32'(k % N)) begin
                n_fail++; $display("FAIL rr_order%0d: got g=%0d d=%h expected %0d/%h", k, seq[k], dat[k], k % N, 32'h100 + 32'(k % N));
            end
        end
    endtask

    task automatic test_resp_backpressure();
        logic [W-1:0] rx [$];
        int idx = 0;
        logic tog = 1'b1;
        do_reset();
        s_tvalid = 4'b0010; s_tlast = 4'b0010; s_tdata[1*W +: W] = 32'h11; eng_in_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        s_tvalid = '0; s_tlast = '0;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            m_tready = {2'b11, tog, 1'b1};
            eng_out_tvalid = 1'b1; eng_out_tdata = 32'hB0 + 32'(idx); eng_out_tlast = (idx == 3);
            #1;
            n_checks++; if ((m_tvalid & 4'b1101) !== 4'd0 || eng_out_tready !== tog) begin
                n_fail++; $display("FAIL bp_route: got m_v=%b out_r=%0b expected x0x0-free/%0b", m_tvalid, eng_out_tready, tog);
            end
            if (m_tvalid[1] && m_tready[1]) rx.push_back(m_tdata[1*W +: W]);
            if (eng_out_tvalid && eng_out_tready) idx++;
            tog = ~tog;
            @(negedge clk);
        end
        eng_out_tvalid = 1'b0; eng_out_tlast = 1'b0;
        #1;
        n_checks++; if (rx.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 4", rx.size()); end
        for (int k = 0; k < rx.size() && k < 4; k++) begin
            n_checks++; if (rx[k] !== 32'hB0 + 32'(k)) begin
                n_fail++; $display("FAIL bp_data%0d: got %h expected %h", k, rx[k], 32'hB0 + 32'(k));
            end
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_resp_stall();
        do_reset();
        s_tvalid = 4'b0001; s_tlast = '0; s_tdata[W-1:0] = 32'h55; eng_in_tready = 1'b1;
        eng_out_tvalid = 1'b1; eng_out_tlast = 1'b1; eng_out_tdata = 32'hD0; m_tready = '1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) s_tlast[0] = 1'b1;
            #1;
            n_checks++; if (eng_out_tready !== 1'b0 || m_tvalid !== 4'd0) begin
                n_fail++; $display("FAIL st_stall%0d: got out_r=%0b m_v=%b expected 0/0000", c, eng_out_tready, m_tvalid);
            end
            @(negedge clk);
        end
        s_tvalid = '0; s_tlast = '0;
        #1;
        n_checks++; if (eng_out_tready !== 1'b1 || m_tvalid !== 4'b0001 || m_tdata[W-1:0] !== 32'hD0) begin
            n_fail++; $display("FAIL st_release: got out_r=%0b m_v=%b d=%h expected 1/0001/d0", eng_out_tready, m_tvalid, m_tdata[W-1:0]);
        end
        @(negedge clk);
        eng_out_tvalid = 1'b0; eng_out_tlast = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_done: got busy=%0b expected 0", busy); end
    endtask

    task automatic test_reset_midpacket();
        do_reset();
        s_tvalid = 4'b1000; s_tdata[3*W +: W] = 32'h30; eng_in_tready = 1'b1; m_tready = '1;
        @(negedge clk);
        @(negedge clk);
        s_tdata[3*W +: W] = 32'h31;
        #1;
        n_checks++; if (eng_in_tvalid !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++; $display("FAIL rm_pre: got in_v=%0b g=%0d expected 1/3", eng_in_tvalid, grant_id);
        end
        resetn = 1'b0;
        #1;
        n_checks++; if ({eng_in_tvalid, eng_out_tready, busy, s_tready, m_tvalid, grant_id} !== 13'd0 || eng_in_tdata !== '0) begin
            n_fail++; $display("FAIL rm_async: got in_v=%0b out_r=%0b busy=%0b s_r=%b m_v=%b g=%0d d=%h expected all 0",
                               eng_in_tvalid, eng_out_tready, busy, s_tready, m_tvalid, grant_id, eng_in_tdata);
        end
        @(negedge clk);
        resetn = 1'b1;
        s_tvalid = 4'b1010; s_tlast = 4'b1010;
        s_tdata[1*W +: W] = 32'h41; s_tdata[3*W +: W] = 32'h32;
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd1 || busy !== 1'b1 || eng_in_tdata !== 32'h41 || s_tready !== 4'b0010) begin
            n_fail++; $display("FAIL rm_regrant: got g=%0d busy=%0b d=%h s_r=%b expected 1/1/41/0010", grant_id, busy, eng_in_tdata, s_tready);
        end
    endtask

    task automatic test_random();
        int             phase;   // 0 = waiting, 1 = request pass-through, 2 = response pass-through
        logic [CHW-1:0] g, last;
        int             len [N];
        int             bidx [N];
        logic           pend [N];
        logic [W-1:0]   pdata [N][4];
        int             rlen, ridx;
        int             mcnt [N];
        logic [N-1:0]   exp_sready, exp_mvalid;
        logic           exp_inv, exp_outr;
        do_reset();
        phase = 0; g = '0; last = CHW'(N - 1); rlen = 1; ridx = 0;
        for (int ch = 0; ch < N; ch++) begin pend[ch] = 1'b0; len[ch] = 1; bidx[ch] = 0; mcnt[ch] = 0; end
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                if (!pend[ch] && ($urandom % 3 == 0)) begin
                    pend[ch] = 1'b1; len[ch] = int'($urandom_range(1, 4)); bidx[ch] = 0;
                    for (int b = 0; b < 4; b++) pdata[ch][b] = $urandom;
                end
                s_tvalid[ch] = pend[ch] && ($urandom % 5 != 0);
                s_tdata[ch*W +: W] = pend[ch] ? pdata[ch][bidx[ch]] : $urandom;
                s_tlast[ch] = pend[ch] ? (bidx[ch] == len[ch] - 1) : 1'($urandom);
            end
            eng_in_tready  = ($urandom % 4 != 0);
            m_tready       = N'($urandom);
            eng_out_tvalid = ($urandom % 3 != 0);
            eng_out_tdata  = $urandom;
            eng_out_tlast  = (phase == 2) ? (ridx == rlen - 1) : 1'($urandom);
            #1;
            exp_inv    = (phase == 1) ? s_tvalid[g] : 1'b0;
            exp_sready = (phase == 1) ? (N'(eng_in_tready) << g) : '0;
            exp_outr   = (phase == 2) ? m_tready[g] : 1'b0;
            exp_mvalid = (phase == 2) ? (N'(eng_out_tvalid) << g) : '0;
            n_checks++; if (busy !== (phase != 0) || eng_in_tvalid !== exp_inv || eng_out_tready !== exp_outr) begin
                n_fail++; $display("FAIL rnd_ctrl c=%0d: got busy=%0b in_v=%0b out_r=%0b expected %0b/%0b/%0b",
                                   c, busy, eng_in_tvalid, eng_out_tready, (phase != 0), exp_inv, exp_outr);
            end
            n_checks++; if (s_tready !== exp_sready || m_tvalid !== exp_mvalid) begin
                n_fail++; $display("FAIL rnd_route c=%0d: got s_r=%b m_v=%b expected %b/%b", c, s_tready, m_tvalid, exp_sready, exp_mvalid);
            end
            if (phase != 0) begin
                n_checks++; if (grant_id !== g) begin n_fail++; $display("FAIL rnd_grant c=%0d: got %0d expected %0d", c, grant_id, g); end
            end
            if (phase == 1 && s_tvalid[g]) begin
                n_checks++; if (eng_in_tdata !== pdata[g][bidx[g]] || eng_in_tlast !== (bidx[g] == len[g] - 1)) begin
                    n_fail++; $display("FAIL rnd_req_data c=%0d: got %h/%0b expected %h/%0b", c, eng_in_tdata, eng_in_tlast, pdata[g][bidx[g]], (bidx[g] == len[g] - 1));
                end
            end
            if (phase == 2) begin
                n_checks++; if (m_tdata[g*W +: W] !== eng_out_tdata || m_tlast[g] !== eng_out_tlast) begin
                    n_fail++; $display("FAIL rnd_resp_data c=%0d: got %h/%0b expected %h/%0b", c, m_tdata[g*W +: W], m_tlast[g], eng_out_tdata, eng_out_tlast);
                end
            end
            // Advance the model by what happens at the coming rising edge
            case (phase)
                0: if (|s_tvalid) begin g = rr_pick(last, s_tvalid); phase = 1; end
                1: if (s_tvalid[g] && eng_in_tready) begin
                       if (bidx[g] == len[g] - 1) begin
                           pend[g] = 1'b0; phase = 2; rlen = int'($urandom_range(1, 3)); ridx = 0;
                       end else begin
                           bidx[g]++;
                       end
                   end
                default: if (eng_out_tvalid && m_tready[g]) begin
                       if (ridx == rlen - 1) begin phase = 0; last = g; mcnt[g]++; end
                       else ridx++;
                   end
            endcase
        end
`ifdef AES_MUX_PKT_CNT_EN
        @(negedge clk);
        #1;
        for (int ch = 0; ch < N; ch++) begin
            n_checks++; if (pkt_cnt[ch*16 +: 16] !== 16'(mcnt[ch])) begin
                n_fail++; $display("FAIL rnd_pkt_cnt%0d: got %0d expected %0d", ch, pkt_cnt[ch*16 +: 16], mcnt[ch]);
            end
        end
`endif
    endtask

`ifdef AES_MUX_PKT_CNT_EN
    task automatic test_pkt_cnt();
        do_reset();
        s_tvalid = 4'b0001; s_tlast = 4'b0001; eng_in_tready = 1'b1;
        eng_out_tvalid = 1'b1; eng_out_tlast = 1'b1; m_tready = '1;
        repeat (9) @(negedge clk);
        s_tvalid = '0;
        #1;
        n_checks++; if (pkt_cnt !== 64'd3) begin n_fail++; $display("FAIL pc_three: got %h expected 3", pkt_cnt); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_resp_backpressure();
        test_resp_stall();
        test_reset_midpacket();
        test_random();
`ifdef AES_MUX_PKT_CNT_EN
        test_pkt_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
